// File: rtl/segre_tlb_refill_ctrl.sv
// Shared ITLB/DTLB refill controller: round-robin arbitration, one-level PTE walk, TLB write pulse.
// Optional invalid-PTE fault reporting is enabled with SEGRE_TLB_REFILL_FAULT_EN.
module segre_tlb_refill_ctrl #(
  parameter int WORD_SIZE      = 32,
  parameter int VIRT_PAGE_BITS = 20,
  parameter int PHYS_PAGE_BITS = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [WORD_SIZE-1:0]      ptbr_i,
  input  logic                      itlb_miss_i,
  input  logic [VIRT_PAGE_BITS-1:0] itlb_vpage_i,
  output logic                      itlb_we_o,
  input  logic                      dtlb_miss_i,
  input  logic [VIRT_PAGE_BITS-1:0] dtlb_vpage_i,
  output logic                      dtlb_we_o,
  output logic [VIRT_PAGE_BITS-1:0] refill_vpage_o,
  output logic [PHYS_PAGE_BITS-1:0] refill_ppage_o,
  output logic [1:0]                refill_mode_o,
  output logic                      mem_req_o,
  output logic [WORD_SIZE-1:0]      mem_addr_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [WORD_SIZE-1:0]      mem_rdata_i,
`ifdef SEGRE_TLB_REFILL_FAULT_EN
  output logic                      itlb_fault_o,
  output logic                      dtlb_fault_o,
`endif
  output logic                      busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Requester ids: 1'b0 = ITLB, 1'b1 = DTLB.
  state_t                      state_r;
  logic                        last_served_r;
  logic                        winner_r;
  logic [VIRT_PAGE_BITS-1:0]   vpage_r;
  logic                        grant_dtlb_s;
  logic [VIRT_PAGE_BITS-1:0]   sel_vpage_s;
  logic                        pte_valid_s;

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    grant_dtlb_s = 1'b0;
    if (itlb_miss_i && dtlb_miss_i) begin
      grant_dtlb_s = ~last_served_r;
    end else if (dtlb_miss_i) begin
      grant_dtlb_s = 1'b1;
    end else begin
      grant_dtlb_s = 1'b0;
    end
    sel_vpage_s = grant_dtlb_s ? dtlb_vpage_i : itlb_vpage_i;
  end

  // PTE valid bit only matters when invalid-PTE faults are reported.
  always_comb begin
`ifdef SEGRE_TLB_REFILL_FAULT_EN
    pte_valid_s = mem_rdata_i[WORD_SIZE-1];
`else
    pte_valid_s = 1'b1;
`endif
  end

  // Walk FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r        <= ST_IDLE;
      last_served_r  <= 1'b0;
      winner_r       <= 1'b0;
      vpage_r        <= {VIRT_PAGE_BITS{1'b0}};
      itlb_we_o      <= 1'b0;
      dtlb_we_o      <= 1'b0;
      refill_vpage_o <= {VIRT_PAGE_BITS{1'b0}};
      refill_ppage_o <= {PHYS_PAGE_BITS{1'b0}};
      refill_mode_o  <= 2'b00;
      mem_req_o      <= 1'b0;
      mem_addr_o     <= {WORD_SIZE{1'b0}};
      busy_o         <= 1'b0;
`ifdef SEGRE_TLB_REFILL_FAULT_EN
      itlb_fault_o   <= 1'b0;
      dtlb_fault_o   <= 1'b0;
`endif
    end else begin
      itlb_we_o    <= 1'b0;
      dtlb_we_o    <= 1'b0;
`ifdef SEGRE_TLB_REFILL_FAULT_EN
      itlb_fault_o <= 1'b0;
      dtlb_fault_o <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (itlb_miss_i || dtlb_miss_i) begin
            winner_r      <= grant_dtlb_s;
            last_served_r <= grant_dtlb_s;
            vpage_r       <= sel_vpage_s;
            // Address wraps modulo 2^WORD_SIZE by truncation of the sum.
            mem_addr_o    <= ptbr_i + {{(WORD_SIZE-VIRT_PAGE_BITS-2){1'b0}}, sel_vpage_s, 2'b00};
            mem_req_o     <= 1'b1;
            busy_o        <= 1'b1;
            state_r       <= ST_REQ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state_r   <= ST_WAIT;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid_i) begin
            state_r <= ST_WRITE;
            if (pte_valid_s) begin
              refill_vpage_o <= vpage_r;
              refill_ppage_o <= mem_rdata_i[PHYS_PAGE_BITS-1:0];
              refill_mode_o  <= mem_rdata_i[30:29];
              itlb_we_o      <= ~winner_r;
              dtlb_we_o      <= winner_r;
            end
`ifdef SEGRE_TLB_REFILL_FAULT_EN
            else begin
              itlb_fault_o <= ~winner_r;
              dtlb_fault_o <= winner_r;
            end
`endif
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_WRITE: begin
          busy_o  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          mem_req_o <= 1'b0;
          busy_o    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_segre_tlb_refill_ctrl.sv
// Directed scoreboard bench for segre_tlb_refill_ctrl; covers SEGRE_TLB_REFILL_FAULT_EN when defined.
module tb_segre_tlb_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ptbr;
  logic        itlb_miss, dtlb_miss;
  logic [19:0] itlb_vpage, dtlb_vpage;
  logic        itlb_we, dtlb_we;
  logic [19:0] refill_vpage;
  logic [7:0]  refill_ppage;
  logic [1:0]  refill_mode;
  logic        mem_req, mem_gnt, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_rdata;
`ifdef SEGRE_TLB_REFILL_FAULT_EN
  logic        itlb_fault, dtlb_fault;
`endif

  typedef struct packed {
    logic        is_d;
    logic        fault;
    logic [19:0] vpage;
    logic [7:0]  ppage;
    logic [1:0]  mode;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   itlb_pulses = 0;
  int   dtlb_pulses = 0;

  segre_tlb_refill_ctrl dut (
    .clk_i(clk), .rst_i(rst), .ptbr_i(ptbr),
    .itlb_miss_i(itlb_miss), .itlb_vpage_i(itlb_vpage), .itlb_we_o(itlb_we),
    .dtlb_miss_i(dtlb_miss), .dtlb_vpage_i(dtlb_vpage), .dtlb_we_o(dtlb_we),
    .refill_vpage_o(refill_vpage), .refill_ppage_o(refill_ppage), .refill_mode_o(refill_mode),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
`ifdef SEGRE_TLB_REFILL_FAULT_EN
    .itlb_fault_o(itlb_fault), .dtlb_fault_o(dtlb_fault),
`endif
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (itlb_we) itlb_pulses <= itlb_pulses + 1;
    if (dtlb_we) dtlb_pulses <= dtlb_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Waits for the request, grants after gnt_wait idle cycles, returns data rv_wait cycles after gnt.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input int gnt_wait,
                       input int rv_wait, input logic [31:0] rdata,
                       output int latency, output int req_cycles);
    latency = 0;
    req_cycles = 0;
    @(negedge clk);
    while (!mem_req && latency < 20) begin
      @(negedge clk);
      latency++;
    end
    check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, "_addr"}, mem_addr, exp_addr);
    repeat (gnt_wait) begin
      if (mem_req) req_cycles++;
      check({tag, "_addr_hold"}, mem_addr, exp_addr);
      check({tag, "_busy_req"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    if (mem_req) req_cycles++;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
    repeat (rv_wait - 1) begin
      check({tag, "_busy_wait"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hDEAD_BEEF;
  endtask

  // Compares the write (or fault) cycle against the oldest scoreboard entry.
  task automatic check_write(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_itlb_we"}, {31'd0, itlb_we}, {31'd0, ~e.is_d & ~e.fault});
    check({tag, "_dtlb_we"}, {31'd0, dtlb_we}, {31'd0, e.is_d & ~e.fault});
    if (!e.fault) begin
      check({tag, "_vpage"}, {12'd0, refill_vpage}, {12'd0, e.vpage});
      check({tag, "_ppage"}, {24'd0, refill_ppage}, {24'd0, e.ppage});
      check({tag, "_mode"}, {30'd0, refill_mode}, {30'd0, e.mode});
    end
`ifdef SEGRE_TLB_REFILL_FAULT_EN
    check({tag, "_itlb_fault"}, {31'd0, itlb_fault}, {31'd0, ~e.is_d & e.fault});
    check({tag, "_dtlb_fault"}, {31'd0, dtlb_fault}, {31'd0, e.is_d & e.fault});
`endif
    if (e.is_d) dtlb_miss = 1'b0;
    else        itlb_miss = 1'b0;
    @(negedge clk);
    check({tag, "_we_end"}, {30'd0, itlb_we, dtlb_we}, 32'd0);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
`ifdef SEGRE_TLB_REFILL_FAULT_EN
    check({tag, "_fault_end"}, {30'd0, itlb_fault, dtlb_fault}, 32'd0);
`endif
  endtask

  initial begin
    int lat, reqc, ip, dp;
    rst = 1'b1; ptbr = 32'd0;
    itlb_miss = 1'b0; dtlb_miss = 1'b0; itlb_vpage = 20'd0; dtlb_vpage = 20'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_we", {30'd0, itlb_we, dtlb_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_refill", {2'd0, refill_vpage, refill_mode, refill_ppage}, 32'd0);
    rst = 1'b0;

    // Single DTLB miss at minimum latency.
    ip = itlb_pulses; dp = dtlb_pulses;
    ptbr = 32'h0000_1000; dtlb_vpage = 20'h00012; dtlb_miss = 1'b1;
    sb.push_back('{1'b1, 1'b0, 20'h00012, 8'h34, 2'd0});
    serve("single", 32'h0000_1048, 0, 1, 32'h8000_0034, lat, reqc);
    check("single_latency", lat, 32'd0);
    check_write("single");
    check("single_pulses", {itlb_pulses - ip, dtlb_pulses - dp}, {32'd0, 32'd1});

    // Tie after a DTLB grant: ITLB wins, then DTLB.
    ip = itlb_pulses; dp = dtlb_pulses;
    ptbr = 32'h0000_2000;
    itlb_vpage = 20'h00100; dtlb_vpage = 20'h00200; itlb_miss = 1'b1; dtlb_miss = 1'b1;
    sb.push_back('{1'b0, 1'b0, 20'h00100, 8'hA1, 2'd2});
    serve("tie1_i", 32'h0000_2400, 0, 1, 32'hC000_00A1, lat, reqc);
    dtlb_vpage = 20'h00201;
    check_write("tie1_i");
    dtlb_vpage = 20'h00200;
    sb.push_back('{1'b1, 1'b0, 20'h00200, 8'hB2, 2'd1});
    serve("tie1_d", 32'h0000_2800, 0, 1, 32'hA000_00B2, lat, reqc);
    check_write("tie1_d");
    check("tie1_pulses", {itlb_pulses - ip, dtlb_pulses - dp}, {32'd1, 32'd1});

    // Address wrap on an ITLB miss.
    ptbr = 32'hFFFF_FFF0; itlb_vpage = 20'h00008; itlb_miss = 1'b1;
    sb.push_back('{1'b0, 1'b0, 20'h00008, 8'h7F, 2'd0});
    serve("wrap", 32'h0000_0010, 0, 1, 32'h8000_007F, lat, reqc);
    check_write("wrap");

    // Tie after an ITLB grant: DTLB wins first.
    ptbr = 32'h0000_0000;
    itlb_vpage = 20'h00300; dtlb_vpage = 20'h00400; itlb_miss = 1'b1; dtlb_miss = 1'b1;
    sb.push_back('{1'b1, 1'b0, 20'h00400, 8'h44, 2'd0});
    serve("tie2_d", 32'h0000_1000, 0, 1, 32'h8000_0044, lat, reqc);
    check_write("tie2_d");
    sb.push_back('{1'b0, 1'b0, 20'h00300, 8'h33, 2'd3});
    serve("tie2_i", 32'h0000_0C00, 0, 1, 32'hE000_0033, lat, reqc);
    check_write("tie2_i");

    // Memory backpressure: gnt 5 cycles late, rvalid 3 cycles after gnt.
    ip = itlb_pulses; dp = dtlb_pulses;
    ptbr = 32'h0000_4000; dtlb_vpage = 20'h00055; dtlb_miss = 1'b1;
    sb.push_back('{1'b1, 1'b0, 20'h00055, 8'h99, 2'd3});
    serve("bp", 32'h0000_4154, 5, 3, 32'hE000_0099, lat, reqc);
    check("bp_req_cycles", reqc, 32'd6);
    check_write("bp");
    check("bp_pulses", {itlb_pulses - ip, dtlb_pulses - dp}, {32'd0, 32'd1});

    // Reset during WAIT; the late response must be dropped.
    ip = itlb_pulses; dp = dtlb_pulses;
    itlb_vpage = 20'h00077; itlb_miss = 1'b1;
    @(negedge clk);
    check("rstw_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; itlb_miss = 1'b0;
    check("rstw_in_wait", {30'd0, mem_req, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h8000_0011;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rstw_outs", {30'd0, mem_req, busy}, 32'd0);
    check("rstw_addr", mem_addr, 32'd0);
    check("rstw_refill", {2'd0, refill_vpage, refill_mode, refill_ppage}, 32'd0);
    @(negedge clk);
    check("rstw_no_we", {30'd0, itlb_we, dtlb_we}, 32'd0);
    check("rstw_pulses", {itlb_pulses - ip, dtlb_pulses - dp}, {32'd0, 32'd0});
    ptbr = 32'h0000_0000; dtlb_vpage = 20'h00066; dtlb_miss = 1'b1;
    sb.push_back('{1'b1, 1'b0, 20'h00066, 8'h21, 2'd0});
    serve("after_rst", 32'h0000_0198, 0, 1, 32'h8000_0021, lat, reqc);
    check("after_rst_latency", lat, 32'd0);
    check_write("after_rst");

    // PTE with V=0: fault when reporting is built in, otherwise written as usual.
    ip = itlb_pulses;
    itlb_vpage = 20'h00003; itlb_miss = 1'b1;
`ifdef SEGRE_TLB_REFILL_FAULT_EN
    sb.push_back('{1'b0, 1'b1, 20'h00003, 8'h55, 2'd0});
`else
    sb.push_back('{1'b0, 1'b0, 20'h00003, 8'h55, 2'd0});
`endif
    serve("inval", 32'h0000_000C, 0, 1, 32'h0000_0055, lat, reqc);
    check_write("inval");
`ifdef SEGRE_TLB_REFILL_FAULT_EN
    check("inval_no_we", itlb_pulses - ip, 32'd0);
`else
    check("inval_we", itlb_pulses - ip, 32'd1);
`endif

    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
